// File: rtl/bincount_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bincount_seq_ctrl
//  Description : Run-control sequencer for an Nbits binary counter. Handles
//                start / pause / stop / terminal count with a prescaled step,
//                a one-cycle done pulse, a busy level and optional auto-reload
//                for periodic interval timing.
//  Revision    : 1.0  initial release
// ============================================================================
module bincount_seq_ctrl #(
    parameter int Nbits = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [Nbits-1:0] term,
    output logic [Nbits-1:0] counter,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    // Prescaler width; DIV=1 still gets a one-bit register that never leaves 0.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t             state_q;
    logic [Nbits-1:0]   counter_q;
    logic [Nbits-1:0]   term_r;
    logic [DIV_W-1:0]   div_cnt;
    logic               busy_q;
    logic               done_q;

    logic               at_term;
    logic               div_wrap;
    logic [DIV_W-1:0]   div_next;
    logic [Nbits-1:0]   cnt_next;

    // Next values for one running step: advance the prescaler, and bump the
    // counter only when the prescaler wraps.
    always_comb begin
        at_term  = (counter_q == term_r);
        div_wrap = (div_cnt == DIV_LAST);
        div_next = div_cnt + DIV_W'(1);
        cnt_next = counter_q;
        if (div_wrap) begin
            div_next = '0;
            cnt_next = counter_q + Nbits'(1);
        end
    end

    // Sequencer: state, counter, latched terminal, prescaler and registered flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            term_r    <= '0;
            div_cnt   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // stop has no effect here, so start+stop still starts.
                    if (start) begin
                        term_r    <= term;
                        counter_q <= '0;
                        div_cnt   <= '0;
                        state_q   <= S_RUN;
                        busy_q    <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (pause) begin
                        state_q <= S_HOLD;
                    end else if (at_term) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        div_cnt   <= div_next;
                        counter_q <= cnt_next;
                    end
                end

                S_HOLD: begin
                    // The resume cycle does the work a RUN cycle would have
                    // done, so each paused cycle costs exactly one cycle and
                    // the prescaler phase carries straight through.
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (!pause) begin
                        if (at_term) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_RUN;
                            div_cnt   <= div_next;
                            counter_q <= cnt_next;
                        end
                    end
                end

                S_DONE: begin
                    done_q <= 1'b0;
                    if (auto_reload) begin
                        term_r    <= term;
                        counter_q <= '0;
                        div_cnt   <= '0;
                        state_q   <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign counter = counter_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_bincount_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bincount_seq_ctrl
//  Description : Directed self-checking bench for bincount_seq_ctrl, with one
//                DIV=1 instance and one DIV=3 instance sharing most inputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bincount_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start1, start3, stop, pause, auto_reload;
    logic [3:0] term;

    logic [3:0] counter1, counter3;
    logic       busy1, busy3, done1, done3;
    logic [1:0] state1, state3;

    int passed = 0;
    int total  = 0;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    always #5 clk = ~clk;

    bincount_seq_ctrl #(.Nbits(4), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .term(term),
        .counter(counter1), .busy(busy1), .done(done1), .state(state1)
    );

    bincount_seq_ctrl #(.Nbits(4), .DIV(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .term(term),
        .counter(counter3), .busy(busy3), .done(done3), .state(state3)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start1 = 0; start3 = 0; stop = 0; pause = 0;
        auto_reload = 0; term = 4'd0;
        repeat (2) nedge();
        total++;
        if ({counter1, busy1, done1, state1} !== 8'h00) $display("FAIL reset_dut1 got cnt=%0d busy=%b done=%b st=%b want 0/0/0/00", counter1, busy1, done1, state1);
        else passed++;
        total++;
        if ({counter3, busy3, done3, state3} !== 8'h00) $display("FAIL reset_dut3 got cnt=%0d busy=%b done=%b st=%b want 0/0/0/00", counter3, busy3, done3, state3);
        else passed++;
        rst = 1'b0;
        nedge();
    endtask

    // term=5, DIV=1: counter 0..5, DONE after 6 edges, then IDLE holding 5.
    task automatic test_basic();
        term = 4'd5; start1 = 1'b1;
        nedge(); start1 = 1'b0;
        term = 4'd2;   // mid-run change must be ignored
        for (int k = 0; k <= 5; k++) begin
            total++;
            if (counter1 !== 4'(k) || state1 !== ST_RUN || busy1 !== 1'b1 || done1 !== 1'b0)
                $display("FAIL basic_cyc%0d got cnt=%0d st=%b busy=%b done=%b want cnt=%0d st=01 busy=1 done=0", k, counter1, state1, busy1, done1, k);
            else passed++;
            nedge();
        end
        total++;
        if (done1 !== 1'b1 || state1 !== ST_DONE || counter1 !== 4'd5)
            $display("FAIL basic_done got done=%b st=%b cnt=%0d want 1/11/5", done1, state1, counter1);
        else passed++;
        nedge();
        total++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || state1 !== ST_IDLE || counter1 !== 4'd5)
            $display("FAIL basic_after got done=%b busy=%b st=%b cnt=%0d want 0/0/00/5", done1, busy1, state1, counter1);
        else passed++;
    endtask

    // term=5 with pause high for 3 cycles at counter=2: done 9 cycles after start.
    task automatic test_pause();
        int done_at;
        done_at = -1;
        term = 4'd5; start1 = 1'b1;
        nedge(); start1 = 1'b0;           // cycle 0, counter 0
        nedge(); nedge();                 // cycle 2, counter 2
        pause = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            nedge();
            total++;
            if (state1 !== ST_HOLD || counter1 !== 4'd2 || busy1 !== 1'b1)
                $display("FAIL pause_hold_cyc%0d got st=%b cnt=%0d busy=%b want 10/2/1", k, state1, counter1, busy1);
            else passed++;
        end
        pause = 1'b0;
        nedge();                          // cycle 6
        total++;
        if (state1 !== ST_RUN || counter1 !== 4'd3)
            $display("FAIL pause_resume got st=%b cnt=%0d want 01/3", state1, counter1);
        else passed++;
        for (int k = 7; k <= 20 && done_at < 0; k++) begin
            nedge();
            if (done1 === 1'b1) done_at = k;
        end
        total++;
        if (done_at != 9) $display("FAIL pause_done_latency got %0d want 9", done_at);
        else passed++;
        nedge();
    endtask

    // term=9, stop at counter=3; start+stop together in IDLE still starts.
    task automatic test_stop();
        logic seen_done;
        seen_done = 1'b0;
        term = 4'd9; start1 = 1'b1;
        nedge(); start1 = 1'b0;
        repeat (3) nedge();               // counter 3
        stop = 1'b1;
        nedge(); stop = 1'b0;
        total++;
        if (state1 !== ST_IDLE || counter1 !== 4'd3 || busy1 !== 1'b0)
            $display("FAIL stop_abort got st=%b cnt=%0d busy=%b want 00/3/0", state1, counter1, busy1);
        else passed++;
        for (int k = 0; k < 12; k++) begin
            if (done1 === 1'b1) seen_done = 1'b1;
            nedge();
        end
        total++;
        if (seen_done !== 1'b0 || counter1 !== 4'd3)
            $display("FAIL stop_no_done got done_seen=%b cnt=%0d want 0/3", seen_done, counter1);
        else passed++;
        start1 = 1'b1; stop = 1'b1;
        nedge(); start1 = 1'b0;
        total++;
        if (state1 !== ST_RUN || counter1 !== 4'd0)
            $display("FAIL stop_restart got st=%b cnt=%0d want 01/0", state1, counter1);
        else passed++;
        nedge(); stop = 1'b0;             // stop held -> back to IDLE at counter 0
        total++;
        if (state1 !== ST_IDLE || counter1 !== 4'd0)
            $display("FAIL stop_in_run got st=%b cnt=%0d want 00/0", state1, counter1);
        else passed++;
    endtask

    // auto_reload, term=15: period 17, counter 0..15 without wrap; clear -> IDLE.
    task automatic test_auto_reload();
        logic [3:0] exp_cnt;
        logic [1:0] exp_st;
        logic       exp_done;
        term = 4'd15; auto_reload = 1'b1; start1 = 1'b1;
        nedge(); start1 = 1'b0;
        for (int c = 0; c <= 51; c++) begin
            if (c == 51) begin
                exp_cnt = 4'd15; exp_st = ST_IDLE; exp_done = 1'b0;
            end else if ((c % 17) == 16) begin
                exp_cnt = 4'd15; exp_st = ST_DONE; exp_done = 1'b1;
            end else begin
                exp_cnt = 4'(c % 17); exp_st = ST_RUN; exp_done = 1'b0;
            end
            total++;
            if (counter1 !== exp_cnt || state1 !== exp_st || done1 !== exp_done)
                $display("FAIL reload_cyc%0d got cnt=%0d st=%b done=%b want cnt=%0d st=%b done=%b", c, counter1, state1, done1, exp_cnt, exp_st, exp_done);
            else passed++;
            if (c == 40) auto_reload = 1'b0;
            nedge();
        end
    endtask

    // DIV=3: term=2 holds each value 3 cycles, done at cycle 7; term=0 done at cycle 1.
    task automatic test_prescale();
        term = 4'd2; start3 = 1'b1;
        nedge(); start3 = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            total++;
            if (counter3 !== 4'(c / 3) || state3 !== ST_RUN)
                $display("FAIL div3_cyc%0d got cnt=%0d st=%b want cnt=%0d st=01", c, counter3, state3, c / 3);
            else passed++;
            nedge();
        end
        total++;
        if (done3 !== 1'b1 || counter3 !== 4'd2)
            $display("FAIL div3_done got done=%b cnt=%0d want 1/2", done3, counter3);
        else passed++;
        nedge();
        term = 4'd0; start3 = 1'b1;
        nedge(); start3 = 1'b0;
        total++;
        if (state3 !== ST_RUN || done3 !== 1'b0)
            $display("FAIL term0_cyc0 got st=%b done=%b want 01/0", state3, done3);
        else passed++;
        nedge();
        total++;
        if (done3 !== 1'b1 || state3 !== ST_DONE || counter3 !== 4'd0)
            $display("FAIL term0_done got done=%b st=%b cnt=%0d want 1/11/0", done3, state3, counter3);
        else passed++;
        nedge();
        total++;
        if (state3 !== ST_IDLE || busy3 !== 1'b0)
            $display("FAIL term0_idle got st=%b busy=%b want 00/0", state3, busy3);
        else passed++;
    endtask

    // Asynchronous reset between edges clears immediately; start ignored under reset.
    task automatic test_async_reset();
        term = 4'd9; start1 = 1'b1;
        nedge(); start1 = 1'b0;
        repeat (4) nedge();
        total++;
        if (counter1 !== 4'd4 || state1 !== ST_RUN)
            $display("FAIL areset_pre got cnt=%0d st=%b want 4/01", counter1, state1);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (counter1 !== 4'd0 || state1 !== ST_IDLE || busy1 !== 1'b0 || done1 !== 1'b0)
            $display("FAIL areset_now got cnt=%0d st=%b busy=%b done=%b want 0/00/0/0", counter1, state1, busy1, done1);
        else passed++;
        start1 = 1'b1;
        repeat (2) nedge();
        total++;
        if (state1 !== ST_IDLE || counter1 !== 4'd0)
            $display("FAIL areset_start got st=%b cnt=%0d want 00/0", state1, counter1);
        else passed++;
        start1 = 1'b0; rst = 1'b0;
        nedge();
        total++;
        if (state1 !== ST_IDLE || done1 !== 1'b0)
            $display("FAIL areset_release got st=%b done=%b want 00/0", state1, done1);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_stop();
        test_auto_reload();
        test_prescale();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
